// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for the branch resolution controller: condition-code fields and FSM states.
package branch_resolve_ctrl_pkg;

    localparam int COND_OP_LSB = 0;
    localparam int COND_OP_MSB = 1;
    localparam int COND_ZERO   = 2;
    localparam int COND_INV    = 3;

    localparam logic [1:0] COND_F   = 2'b00;
    localparam logic [1:0] COND_EQ  = 2'b01;
    localparam logic [1:0] COND_LT  = 2'b10;
    localparam logic [1:0] COND_LTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational condition evaluation on the ALU difference d = A - B.
module branch_resolve_ctrl_cond_eval
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic [3:0]       cond,
    input  logic [DBITS-1:0] d,
    output logic             taken
);

    logic eq;
    logic lt;
    logic base;

    // Signed overflow is deliberately ignored: the sign bit alone decides "less than".
    assign eq = (d == '0);
    assign lt = d[DBITS-1];

    always_comb begin
        base = 1'b0;
        unique case (cond[COND_OP_MSB:COND_OP_LSB])
            COND_F:   base = 1'b0;
            COND_EQ:  base = eq;
            COND_LT:  base = lt;
            COND_LTE: base = eq | lt;
            default:  base = 1'b0;
        endcase
    end

    assign taken = base ^ cond[COND_INV];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: arbitrates for the shared ALU, evaluates the condition, hands the
// redirect to fetch. Define BRANCH_STATS_EN to add saturating handoff/taken counters.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cond,
    input  logic [DBITS-1:0] req_srcA,
    input  logic [DBITS-1:0] req_srcB,
    input  logic [DBITS-1:0] req_pc,
    input  logic [DBITS-1:0] req_offset,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [DBITS-1:0] alu_inA,
    output logic [DBITS-1:0] alu_inB,
    input  logic [DBITS-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [DBITS-1:0] res_target
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_taken
`endif
);

    state_e           state_q;
    logic [3:0]       cond_q;
    logic [DBITS-1:0] pc_q;
    logic [DBITS-1:0] off_q;
    logic             alu_req_q;
    logic [DBITS-1:0] alu_ina_q;
    logic [DBITS-1:0] alu_inb_q;
    logic             res_valid_q;
    logic             res_taken_q;
    logic [DBITS-1:0] res_target_q;

    logic [3:0]       eval_cond_d;
    logic [DBITS-1:0] tgt_pc_d;
    logic [DBITS-1:0] tgt_off_d;
    logic [DBITS-1:0] seq_pc_d;
    logic [DBITS-1:0] target_d;
    logic             taken_d;

    // One evaluator serves both the F/T shortcut in IDLE and the ALU result in WAIT.
    always_comb begin
        eval_cond_d = cond_q;
        tgt_pc_d    = pc_q;
        tgt_off_d   = off_q;
        if (state_q == ST_IDLE) begin
            eval_cond_d = req_cond;
            tgt_pc_d    = req_pc;
            tgt_off_d   = req_offset;
        end
        seq_pc_d = tgt_pc_d + DBITS'(4);
        target_d = taken_d ? (seq_pc_d + {tgt_off_d[DBITS-3:0], 2'b00}) : seq_pc_d;
    end

    branch_resolve_ctrl_cond_eval #(.DBITS(DBITS)) u_cond_eval (
        .cond  (eval_cond_d),
        .d     (alu_result),
        .taken (taken_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cond_q       <= '0;
            pc_q         <= '0;
            off_q        <= '0;
            alu_req_q    <= 1'b0;
            alu_ina_q    <= '0;
            alu_inb_q    <= '0;
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_target_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        cond_q    <= req_cond;
                        pc_q      <= req_pc;
                        off_q     <= req_offset;
                        alu_ina_q <= req_srcA;
                        alu_inb_q <= req_cond[COND_ZERO] ? '0 : req_srcB;
                        if (req_cond[COND_OP_MSB:COND_OP_LSB] == COND_F) begin
                            res_taken_q  <= taken_d;
                            res_target_q <= target_d;
                            state_q      <= ST_DONE;
                        end else begin
                            alu_req_q <= 1'b1;
                            state_q   <= ST_ARB;
                        end
                    end
                end
                ST_ARB: begin
                    if (alu_gnt) begin
                        alu_req_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    res_taken_q  <= taken_d;
                    res_target_q <= target_d;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    // First DONE cycle raises valid; the decision is then held until fetch takes it.
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                    end else if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign alu_req    = alu_req_q;
    assign alu_inA    = alu_ina_q;
    assign alu_inB    = alu_inb_q;
    assign res_valid  = res_valid_q;
    assign res_taken  = res_taken_q;
    assign res_target = res_target_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_total_q;
    logic [31:0] stat_taken_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
        end else if (res_valid_q && res_ready) begin
            if (stat_total_q != 32'hFFFF_FFFF) begin
                stat_total_q <= stat_total_q + 32'd1;
            end
            if (res_taken_q && (stat_taken_q != 32'hFFFF_FFFF)) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
        end
    end

    assign stat_total = stat_total_q;
    assign stat_taken = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cond;
    logic [31:0] req_srcA;
    logic [31:0] req_srcB;
    logic [31:0] req_pc;
    logic [31:0] req_offset;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_inA;
    logic [31:0] alu_inB;
    logic [31:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic [31:0] res_target;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_total;
    logic [31:0] stat_taken;
`endif

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_ctrl #(.DBITS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cond   (req_cond),
        .req_srcA   (req_srcA),
        .req_srcB   (req_srcB),
        .req_pc     (req_pc),
        .req_offset (req_offset),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_inA    (alu_inA),
        .alu_inB    (alu_inB),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_taken  (res_taken),
        .res_target (res_target)
`ifdef BRANCH_STATS_EN
        ,
        .stat_total (stat_total),
        .stat_taken (stat_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge right after the accepting rising edge.
    task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] off);
        req_cond   = c;
        req_srcA   = a;
        req_srcB   = b;
        req_pc     = pc;
        req_offset = off;
        req_valid  = 1'b1;
        chk({tag, "_accept_rdy"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic handoff(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_post_valid"}, res_valid, 0);
        chk({tag, "_post_rdy"}, req_ready, 1);
    endtask

    task automatic run_alu(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off, input logic [31:0] res,
                           input int hold, input logic [31:0] exp_b, input logic exp_t,
                           input logic [31:0] exp_tgt);
        int lat;
        issue(tag, c, a, b, pc, off);
        lat = 0;
        alu_result = ~res;
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_req_held"}, alu_req, 1);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_alu_req"}, alu_req, 1);
        chk({tag, "_inA"}, alu_inA, a);
        chk({tag, "_inB"}, alu_inB, exp_b);
        alu_gnt = 1'b1;
        @(negedge clk);
        lat++;
        alu_gnt    = 1'b0;
        alu_result = res;
        chk({tag, "_req_drop"}, alu_req, 0);
        @(negedge clk);
        lat++;
        alu_result = ~res;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 3 + hold);
        chk({tag, "_taken"}, res_taken, exp_t);
        chk({tag, "_target"}, res_target, exp_tgt);
        chk({tag, "_busy"}, req_ready, 0);
        handoff(tag);
    endtask

    // F/T shortcut: returns with res_valid expected high, before handoff.
    task automatic run_ft(input string tag, input logic [3:0] c, input logic [31:0] pc, input logic [31:0] off,
                          input logic exp_t, input logic [31:0] exp_tgt);
        issue(tag, c, 32'h1234_5678, 32'h9ABC_DEF0, pc, off);
        chk({tag, "_no_alu_req"}, alu_req, 0);
        chk({tag, "_valid_early"}, res_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_taken"}, res_taken, exp_t);
        chk({tag, "_target"}, res_target, exp_tgt);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cond   = '0;
        req_srcA   = '0;
        req_srcB   = '0;
        req_pc     = '0;
        req_offset = '0;
        alu_gnt    = 1'b0;
        alu_result = '0;
        res_ready  = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_alu_req", alu_req, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_target", res_target, 0);
        chk("rst_inB", alu_inB, 0);
        reset = 1'b0;
        @(negedge clk);

        // EQ: 0x100 + 4 + (3 << 2) = 0x110
        run_alu("eq", 4'b0001, 32'd5, 32'd5, 32'h100, 32'd3, 32'h0, 0, 32'd5, 1'b1, 32'h110);
        // GT on 2 - 7 (negative) is false
        run_alu("gt", 4'b1011, 32'd2, 32'd7, 32'h200, 32'd5, 32'hFFFF_FFFB, 0, 32'd7, 1'b0, 32'h204);
        // LTZ with srcB masked, gnt withheld 4 cycles; 0x304 + (-2 << 2) = 0x2FC
        run_alu("ltz", 4'b0110, 32'h8000_0010, 32'h55, 32'h300, 32'hFFFF_FFFE, 32'h8000_0010, 4,
                32'h0, 1'b1, 32'h2FC);

        run_ft("f", 4'b0000, 32'h400, 32'h10, 1'b0, 32'h404);
        handoff("f");
        run_ft("t_wrap", 4'b1000, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0000_0000);
        handoff("t_wrap");

        // Stall in DONE with a second request and a stray grant pending
        run_ft("stall", 4'b1000, 32'h1000, 32'h10, 1'b1, 32'h1044);
        req_cond   = 4'b0000;
        req_pc     = 32'h2000;
        req_offset = 32'h40;
        req_valid  = 1'b1;
        alu_gnt    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_taken", res_taken, 1);
            chk("stall_target", res_target, 32'h1044);
            chk("stall_rdy", req_ready, 0);
            chk("stall_gnt_ignored", alu_req, 0);
        end
        alu_gnt   = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("stall_idle_rdy", req_ready, 1);
        chk("stall_idle_valid", res_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("second_accepted", req_ready, 0);
        @(negedge clk);
        chk("second_valid", res_valid, 1);
        chk("second_taken", res_taken, 0);
        chk("second_target", res_target, 32'h2004);
        handoff("second");

`ifdef BRANCH_STATS_EN
        chk("stat_total", stat_total, 7);
        chk("stat_taken", stat_taken, 4);
`endif

        // Asynchronous reset while holding the ALU request
        issue("rst_arb", 4'b0001, 32'd9, 32'd3, 32'h500, 32'd1);
        chk("rst_arb_req_before", alu_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_arb_alu_req", alu_req, 0);
        chk("rst_arb_rdy", req_ready, 1);
        chk("rst_arb_valid", res_valid, 0);
        chk("rst_arb_taken", res_taken, 0);
        chk("rst_arb_target", res_target, 0);
        chk("rst_arb_inA", alu_inA, 0);
`ifdef BRANCH_STATS_EN
        chk("rst_stat_total", stat_total, 0);
        chk("rst_stat_taken", stat_taken, 0);
`endif
        @(negedge clk);
        req_cond  = 4'b1000;
        req_valid = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_ignore_rdy", req_ready, 1);
        chk("rst_ignore_valid", res_valid, 0);
        chk("rst_ignore_req", alu_req, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences conditional-branch resolution for the processor core.
- Accepts one branch request at a time and arbitrates for the shared ALU subtractor to form inA - inB.
- Evaluates the 4-bit condition code on the difference, then presents a taken/not-taken decision and redirect PC to fetch over a valid/ready handshake.
- Sits between decode/execute and fetch; the ALU is shared with the execute datapath through a req/gnt pair.

Parameters:
- DBITS, 32, data and PC width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  branch request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_cond  in  4  condition code (encoding below).
- req_srcA  in  DBITS  first operand.
- req_srcB  in  DBITS  second operand; ignored for zero-compare codes.
- req_pc  in  DBITS  PC of the branch instruction.
- req_offset  in  DBITS  signed word offset.
- alu_req  out  1  request for the shared ALU.
- alu_gnt  in  1  ALU granted this cycle.
- alu_inA  out  DBITS  ALU operand A.
- alu_inB  out  DBITS  ALU operand B.
- alu_result  in  DBITS  inA - inB; valid the cycle after alu_gnt.
- res_valid  out  1  decision available.
- res_ready  in  1  fetch consumes the decision.
- res_taken  out  1  branch taken.
- res_target  out  DBITS  next PC.

Behaviour:
- Condition code:
  - cond[1:0]: 00 = F, 01 = EQ, 10 = LT, 11 = LTE.
  - cond[2] = 1: compare against zero (alu_inB = 0).
  - cond[3] = 1: invert the result (00 becomes T, EQ becomes NE, LT becomes GTE, LTE becomes GT).
- Condition evaluation on d = captured alu_result:
  - eq = (d == 0).
  - lt = d[DBITS-1]. Signed overflow is ignored by definition.
  - lte = eq | lt.
- FSM states are IDLE, ARB, WAIT, DONE.
  - IDLE: req_ready = 1. On req_valid, capture cond, srcA, srcB (zeroed if cond[2]), pc and offset.
    - If cond[1:0] == 00, resolve immediately (taken = cond[3]) and go to DONE.
    - Otherwise go to ARB.
  - ARB: alu_req = 1; alu_inA/alu_inB drive the captured operands. On alu_gnt go to WAIT. The block waits indefinitely without gnt.
  - WAIT: alu_req = 0. Capture alu_result, evaluate the condition, register res_taken and res_target, go to DONE.
  - DONE: res_valid = 1; outputs held stable until res_ready. On res_valid & res_ready go to IDLE.
- No new request is accepted in DONE, so the earliest next acceptance is the cycle after handoff.
- Target arithmetic:
  - taken: res_target = pc + 4 + (offset << 2), modulo 2^DBITS, wrap-around allowed.
  - not taken: res_target = pc + 4.
- Latency from the acceptance edge:
  - ALU path: res_valid rises 3 cycles later when gnt is given in the first ARB cycle, plus one cycle per cycle gnt is withheld.
  - F/T path: 1 cycle.
- alu_gnt seen outside ARB is ignored.
- Reset, asynchronous and valid at any point including mid-operation, forces:
  - state to IDLE, req_ready = 1;
  - alu_req = 0, res_valid = 0, res_taken = 0;
  - res_target = 0, alu_inA = 0, alu_inB = 0.
  - Any in-flight request is dropped and the ALU request is withdrawn immediately.
- req_valid is ignored while reset is high.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds two outputs, stat_total (32 bits) and stat_taken (32 bits).
  - Both increment on each res_valid & res_ready handshake; stat_taken increments only when res_taken.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header: condition-code field positions, the COND_F/EQ/LT/LTE encodings, COND_ZERO and COND_INV bit indices, and FSM state encodings.
- One natural sub-module, cond_eval: combinational, taking cond[3:0] and d[DBITS-1:0] and producing taken. It is instantiated once in the WAIT-capture path and reused for the F/T shortcut.

Test Plan:
- EQ (cond 0001), srcA = 5, srcB = 5, pc = 0x100, offset = 3, gnt immediate, alu_result = 0 -> res_valid 3 cycles after accept, taken = 1, target = 0x110.
- GT (cond 1011), srcA = 2, srcB = 7, alu_result = 0xFFFFFFFB, pc = 0x200 -> taken = 0, target = 0x204.
- LTZ (cond 0110), srcB = 0x55 -> alu_inB = 0 during ARB; alu_gnt withheld 4 cycles -> alu_req held for all 4, res_valid 4 cycles later than the immediate-gnt case.
- T (cond 1000), pc = 0xFFFFFFFC, offset = 0 -> no alu_req, res_valid 1 cycle after accept, taken = 1, target = 0x00000000 (wrap).
- res_ready held low 5 cycles in DONE -> res_taken and res_target stable, req_ready = 0, second req_valid not accepted until after handoff.
- reset pulsed while in ARB with alu_req = 1 -> alu_req drops asynchronously, state IDLE, req_ready = 1, res_valid = 0; with BRANCH_STATS_EN, counters read 0.
